ama_riscv_fetch_queue: RTL
==========================

// Module: ama_riscv_fetch_queue
// PURPOSE
//  Instruction queue between IMEM fetch and the decode stage, which holds the imm generator.
//  Buffers fetched {pc, inst} pairs in a DEPTH-entry circular FIFO with valid/ready on both sides.
//  Decode takes inst_id; inst_id[31:7] drives the imm generator's ig_in.
//  Flush (branch/jump redirect) empties the queue.
//  When empty, decode sees NOP and id_valid=0.
// PARAMETERS
//  DEPTH    4               entries; power of 2, >= 2
//  NOP      32'h0000_0013   inst_id value while empty (addi x0,x0,0)
//  CNT_W    32              width of bubble_cnt
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst         in   1      synchronous, active-high reset
//  flush       in   1      discard all entries (redirect)
//  if_valid    in   1      fetch presents {if_pc, if_inst}
//  if_ready    out  1      queue accepts entry (= !full)
//  if_pc       in   32     PC of fetched instruction
//  if_inst     in   32     fetched instruction word
//  id_valid    out  1      head entry valid (= !empty)
//  id_ready    in   1      decode consumes head this cycle
//  pc_id       out  32     head PC; 32'h0 when empty
//  inst_id     out  32     head instruction; NOP when empty
//  occupancy   out  $clog2(DEPTH+1)   entries held
//  bubble_cnt  out  CNT_W  cycles with id_ready && !id_valid && !flush
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, occupancy=0, bubble_cnt=0.
//    Consequently id_valid=0, if_ready=1, inst_id=NOP, pc_id=0.
//    Storage array is not reset.
//  - push = if_valid && if_ready && !flush.
//    Writes mem[wr_ptr], then wr_ptr++ (wraps mod DEPTH).
//  - pop = id_valid && id_ready && !flush. rd_ptr++ (wraps mod DEPTH).
//  - Outputs are combinational from mem[rd_ptr] and occupancy. No write-to-read bypass.
//    Latency is 1 cycle: an entry pushed at edge N is visible on id_* after edge N.
//  - occupancy: +1 on push only; -1 on pop only; unchanged on push+pop.
//  - Full (occupancy==DEPTH): if_ready=0. A pop in the same cycle does not open the slot
//    until the next cycle.
//  - Empty: id_valid=0, so id_ready is ignored and no underflow is possible.
//  - flush: next cycle wr_ptr=rd_ptr=0, occupancy=0.
//    A push or pop in the same cycle is dropped. if_ready is still driven as !full.
//  - Entry order is preserved through pointer wrap-around.
//  - bubble_cnt increments on qualifying cycles and wraps at 2^CNT_W. flush does not clear it.
//  - rst has priority over flush. Reset mid-stream discards all entries and zeroes bubble_cnt.
//  - Holding if_valid with if_ready=0 pushes nothing. Fetch must hold its data stable.
// TESTING
//  1. Reset, then push {0x0,0x00500093} with id_ready=0.
//     -> Next cycle: id_valid=1, inst_id=0x00500093, pc_id=0, occupancy=1.
//  2. Push 4 entries (PC 0x0..0xC) with id_ready=0.
//     -> occupancy=4, if_ready=0.
//     -> A 5th if_valid is not accepted; pops return PC 0x0,0x4,0x8,0xC in order.
//  3. Full queue with push+pop in the same cycle.
//     -> Pop only; occupancy=3. Push is accepted next cycle, giving occupancy=4.
//  4. Stream 10 entries with id_ready=1 every cycle.
//     -> Pointers wrap. Output PCs increase by 4, with no loss or duplication.
//     -> occupancy stays <= 1.
//  5. occupancy=3, then flush=1 with if_valid=1 in the same cycle.
//     -> Next cycle: occupancy=0, id_valid=0, inst_id=0x00000013, pc_id=0.
//  6. Empty queue with id_ready=1 for 5 cycles -> bubble_cnt=5.
//     -> rst for 1 cycle -> bubble_cnt=0, occupancy=0.

Source files
------------

// File: rtl/ama_riscv_fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular FIFO of {pc, inst} pairs.
// Decode sees the head entry combinationally; an empty queue presents a NOP bubble.
module ama_riscv_fetch_queue #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h0000_0013,
    parameter int          CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [31:0]                if_pc,
    input  logic [31:0]                if_inst,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [31:0]                pc_id,
    output logic [31:0]                inst_id,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           bubble_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;

    logic full, empty, push, pop, bubble;

    // Full/empty come only from registered occupancy, so a same-cycle pop
    // never frees a slot for a same-cycle push.
    assign full   = (occ_q == OCC_W'(DEPTH));
    assign empty  = (occ_q == '0);
    assign push   = if_valid && !full && !flush;
    assign pop    = !empty && id_ready && !flush;
    assign bubble = id_ready && empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        bubble_d = bubble_q + CNT_W'(bubble);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            // DEPTH is a power of 2, so pointer overflow is the wrap.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      occ_d = occ_q + OCC_W'(1);
            else if (pop && !push) occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            bubble_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            bubble_q <= bubble_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= '{pc: if_pc, inst: if_inst};
    end

    assign if_ready   = !full;
    assign id_valid   = !empty;
    assign pc_id      = empty ? 32'h0 : mem_q[rd_ptr_q].pc;
    assign inst_id    = empty ? NOP   : mem_q[rd_ptr_q].inst;
    assign occupancy  = occ_q;
    assign bubble_cnt = bubble_q;

endmodule
